// File: rtl/axil_reg_arbiter_if.sv
// rtl/axil_reg_arbiter_if.sv - AXI4-Lite bus between the arbiter master and the register slave
interface axil_reg_arbiter_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_reg_arbiter.sv
// rtl/axil_reg_arbiter.sv - round-robin two-requester AXI4-Lite master, one transaction at a time
module axil_reg_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    axil_reg_arbiter_if.master      m_axi
);
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

    state_t                state, state_nxt;
    logic                  prio;
    logic                  win;
    logic                  accept;
    logic                  id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  awvalid_q, wvalid_q, arvalid_q;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Pointer only matters when both requesters are valid together.
    assign win       = (&req_valid) ? prio : req_valid[1];
    assign accept    = (state == IDLE) && (|req_valid);
    assign sel_addr  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_we[win] ? WR_ADDR : RD_ADDR;
            WR_ADDR: if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready))
                         state_nxt = WR_RESP;
            WR_RESP: if (m_axi.bvalid) state_nxt = RESP;
            RD_ADDR: if (arvalid_q && m_axi.arready) state_nxt = RD_DATA;
            RD_DATA: if (m_axi.rvalid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;
        m_axi.bready = 1'b0;
        m_axi.rready = 1'b0;
        if (accept)            req_ready = win ? 2'b10 : 2'b01;
        if (state == RESP)     rsp_valid = id_q ? 2'b10 : 2'b01;
        if (state == WR_RESP)  m_axi.bready = 1'b1;
        if (state == RD_DATA)  m_axi.rready = 1'b1;
    end

    // Command latch, registered master valids and response capture.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            prio      <= 1'b0;
            id_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            if (accept) begin
                prio      <= ~win;
                id_q      <= win;
                addr_q    <= sel_addr & ~ADDR_WIDTH'(3);
                wdata_q   <= sel_wdata;
                awvalid_q <= req_we[win];
                wvalid_q  <= req_we[win];
                arvalid_q <= ~req_we[win];
            end else begin
                if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
                if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
                if (arvalid_q && m_axi.arready) arvalid_q <= 1'b0;
            end
            if (state == WR_RESP && m_axi.bvalid) rsp_resp <= m_axi.bresp;
            if (state == RD_DATA && m_axi.rvalid) begin
                rsp_rdata <= m_axi.rdata;
                rsp_resp  <= m_axi.rresp;
            end
        end
    end

    assign m_axi.awaddr  = addr_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.arvalid = arvalid_q;
endmodule

// File: tb/tb_axil_reg_arbiter.sv
// tb/tb_axil_reg_arbiter.sv - directed-vector bench for axil_reg_arbiter with a small register slave
module tb_axil_reg_arbiter;
    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_resp;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rsp_rdata;
    int          cyc = 0;
    int          nvec = 0;
    int          nmis = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axil_reg_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    axil_reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .ACLK(clk), .ARESET(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi(bus)
    );

    // Register-bank slave with programmable ready wait states.
    logic [31:0] mem [4];
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    int          aw_cnt, w_cnt, ar_cnt;
    logic        aw_got, w_got, r_stall;
    logic [3:0]  aw_a, wr_addr, last_araddr;
    logic [31:0] w_d;
    logic [1:0]  rresp_cfg;
    logic        aw_hs, w_hs, ar_hs;

    assign bus.awready = bus.awvalid && (aw_cnt >= aw_wait);
    assign bus.wready  = bus.wvalid && (w_cnt >= w_wait);
    assign bus.arready = bus.arvalid && (ar_cnt >= ar_wait);
    assign bus.bresp   = 2'b00;
    assign aw_hs   = bus.awvalid && bus.awready;
    assign w_hs    = bus.wvalid && bus.wready;
    assign ar_hs   = bus.arvalid && bus.arready;
    assign wr_addr = aw_got ? aw_a : bus.awaddr;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            bus.bvalid <= 1'b0; bus.rvalid <= 1'b0;
            bus.rdata <= '0; bus.rresp <= 2'b00;
        end else begin
            aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
            ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
            if ((aw_got || aw_hs) && (w_got || w_hs) && !bus.bvalid) begin
                bus.bvalid <= 1'b1;
                mem[wr_addr[3:2]] <= w_got ? w_d : bus.wdata;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_a <= bus.awaddr; end
                if (w_hs)  begin w_got <= 1'b1; w_d <= bus.wdata; end
            end
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (ar_hs) begin
                last_araddr <= bus.araddr;
                if (!r_stall) begin
                    bus.rvalid <= 1'b1;
                    bus.rdata  <= mem[bus.araddr[3:2]];
                    bus.rresp  <= rresp_cfg;
                end
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic we, input logic [3:0] addr, input logic [31:0] wd);
        req_valid[id]         = 1'b1;
        req_we[id]            = we;
        req_addr[id*4 +: 4]   = addr;
        req_wdata[id*32 +: 32] = wd;
    endtask

    task automatic wait_ready(input int id);
        int n = 0;
        while (!req_ready[id] && n < 40) begin @(posedge clk); #2; n++; end
    endtask

    task automatic wait_rsp(input int id);
        int n = 0;
        while (!rsp_valid[id] && n < 40) begin @(posedge clk); #2; n++; end
    endtask

    task automatic do_cmd(input string tag, input int id, input logic we, input logic [3:0] addr,
                          input logic [31:0] wd, input logic [1:0] exp_resp,
                          input logic chk_rd, input logic [31:0] exp_rd);
        int acc;
        @(posedge clk); #1;
        set_req(id, we, addr, wd);
        #1;
        wait_ready(id);
        check({tag, "_acc"}, 64'(req_ready[id]), 64'd1);
        acc = cyc;
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        #1;
        wait_rsp(id);
        check({tag, "_lat"}, 64'(cyc - acc), 64'd3);
        check({tag, "_resp"}, 64'(rsp_resp), 64'(exp_resp));
        if (chk_rd) check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a, g, n;
        logic [3:0] bp_exp [6];
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        r_stall = 1'b0; rresp_cfg = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_ctl", 64'({req_ready, rsp_valid, rsp_resp, bus.awvalid, bus.wvalid, bus.arvalid,
                              bus.bready, bus.rready, bus.awaddr, bus.araddr}), 64'd0);
        check("rst_data", {rsp_rdata, bus.wdata}, 64'd0);

        do_cmd("wr8", 0, 1'b1, 4'h8, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0);
        do_cmd("rd8", 0, 1'b0, 4'h8, 32'h0, 2'b00, 1'b1, 32'hDEADBEEF);

        // Contention straight after reset: requester 0 must win first.
        do_reset();
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'h0, 32'h1);
        set_req(1, 1'b1, 4'h4, 32'h2);
        #1;
        check("cont_first", 64'(req_ready), 64'h1);
        a = cyc;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #1;
        wait_ready(1);
        check("cont_gap", 64'(cyc - a), 64'd4);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        #1;
        wait_rsp(1);
        check("cont_rsp1", 64'(rsp_valid), 64'h2);
        do_cmd("cont_rd0", 0, 1'b0, 4'h0, 32'h0, 2'b00, 1'b1, 32'h1);
        do_cmd("cont_rd4", 1, 1'b0, 4'h4, 32'h0, 2'b00, 1'b1, 32'h2);

        // Fairness: both hold valid for eight grants.
        do_reset();
        @(posedge clk); #1;
        set_req(0, 1'b0, 4'h0, 32'h0);
        set_req(1, 1'b0, 4'h4, 32'h0);
        #1;
        g = 0; n = 0;
        while (g < 8 && n < 200) begin
            if (req_ready != 2'b00) begin
                check($sformatf("fair_%0d", g), 64'(req_ready), (g % 2 != 0) ? 64'h2 : 64'h1);
                g++;
            end
            if (g < 8) begin @(posedge clk); #2; n++; end
        end
        check("fair_count", 64'(g), 64'd8);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (8) @(posedge clk);

        // Backpressure: AWREADY 3 waits, WREADY 1 wait; sample {awvalid,wvalid,bready,rsp_valid[0]}.
        aw_wait = 3; w_wait = 1;
        bp_exp = '{4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0010, 4'b0001};
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'hC, 32'h55);
        #1;
        wait_ready(0);
        check("bp_acc", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("bp_c%0d", k + 1),
                  64'({bus.awvalid, bus.wvalid, bus.bready, rsp_valid[0]}), 64'(bp_exp[k]));
            if (k < 5) begin @(posedge clk); #2; end
        end
        aw_wait = 0; w_wait = 0;
        do_cmd("bp_rdc", 0, 1'b0, 4'hC, 32'h0, 2'b00, 1'b1, 32'h55);

        // Unaligned read with slave error.
        rresp_cfg = 2'b10;
        do_cmd("err", 0, 1'b0, 4'h6, 32'h0, 2'b10, 1'b0, 32'h0);
        check("err_araddr", 64'(last_araddr), 64'h4);
        rresp_cfg = 2'b00;

        // Reset while waiting in RD_DATA.
        r_stall = 1'b1;
        @(posedge clk); #1;
        set_req(0, 1'b0, 4'h8, 32'h0);
        #1;
        wait_ready(0);
        check("mr_acc", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mr_in_rd_data", 64'(bus.rready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        r_stall = 1'b0;
        #1;
        check("mr_ctl", 64'({rsp_valid, rsp_resp, bus.awvalid, bus.wvalid, bus.arvalid,
                             bus.bready, bus.rready, bus.awaddr, bus.araddr}), 64'd0);
        check("mr_data", {rsp_rdata, bus.wdata}, 64'd0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 4'h0, 32'h0);
        set_req(1, 1'b0, 4'h4, 32'h0);
        #1;
        check("mr_prio", 64'(req_ready), 64'h1);
        a = cyc;
        @(posedge clk); #1;
        req_valid = 2'b00;
        #1;
        wait_rsp(0);
        check("mr_lat", 64'(cyc - a), 64'd3);
        check("mr_rdata", 64'(rsp_rdata), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/axil_reg_arbiter.md
# axil_reg_arbiter

Two-requester AXI4-Lite master arbiter that shares one AXI4-Lite slave register bank (the 4 x 32-bit miniprojectip S00_AXI registers) between two on-chip command sources. Each requester issues single-word read or write commands over a simple valid/ready port. The block grants round-robin, runs one AXI4-Lite transaction at a time on its master port and returns a one-cycle response pulse to the winner. It sits between the command sources and the S00_AXI slave interface of the register IP.

## Interface
- ADDR_WIDTH, 4: byte-address width on the request ports and M_AXI_AWADDR/ARADDR.
- DATA_WIDTH, 32: fixed at 32 (AXI4-Lite); other values unsupported.
- ACLK  in  1  single clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester command valid (bit n = requester n).
- req_ready  out  2  per-requester command accept, one-hot or zero.
- req_we  in  2  1 = write, 0 = read.
- req_addr  in  2*ADDR_WIDTH  byte address; requester n in slice n.
- req_wdata  in  2*32  write data; requester n in slice n.
- rsp_valid  out  2  one-cycle response pulse to the requester that was served.
- rsp_rdata  out  32  read data; held until the next response.
- rsp_resp  out  2  AXI response code (BRESP or RRESP); held until the next response.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master, ADDR_WIDTH address, 32-bit data.

## Operation
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: if any req_valid bit is set, pick the winner.
  - Both valid: the winner is the requester indicated by the priority pointer.
  - Otherwise: the winner is the single valid requester.
  - req_ready[winner] = 1 combinationally in that cycle. The command (we, addr, wdata, id) is latched.
  - Next state is WR_ADDR or RD_ADDR.
  - The priority pointer is set to the non-winner.
- req_ready is 0 in every state except IDLE.
- WR_ADDR: AWVALID and WVALID assert together.
  - Each drops independently after its own handshake (AWREADY or WREADY high while valid).
  - Go to WR_RESP once both handshakes have completed, in the same cycle or different cycles.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP and go to RESP.
- RD_ADDR: ARVALID = 1 until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, capture RDATA and RRESP, then go to RESP.
- RESP: rsp_valid[id] = 1 for exactly one cycle, then go to IDLE. Responses have no backpressure.
  - After a write, rsp_rdata holds its previous value.
- Address handling: AWADDR/ARADDR = latched addr with bits [1:0] forced to 0. WSTRB = 4'hF. AWPROT = ARPROT = 3'b000.
- The block never retries and never times out. SLVERR/DECERR codes are passed through unchanged in rsp_resp.

## Timing
- Reset (ARESET high at a rising edge):
  - State goes to IDLE and the priority pointer to requester 0.
  - All VALID/READY outputs, rsp_valid, rsp_rdata and rsp_resp are 0. Address and data outputs are 0.
- Reset mid-transaction: the transaction is abandoned at the next edge, all master valids drop and no rsp_valid is issued. Slave-side recovery is the system's responsibility.
- Master valids are registered. They rise the cycle after the accept.
- Zero-wait-state slave, write: accept at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2 (earliest), rsp_valid at cycle 3, next accept at cycle 4.
- Zero-wait-state slave, read: accept at cycle 0, AR handshake at cycle 1, R handshake at cycle 2, rsp_valid at cycle 3, next accept at cycle 4.
- Each wait cycle on a slave READY or VALID adds exactly one cycle.
- Once asserted, AWVALID, WVALID and ARVALID stay high with stable address and data until their handshake.
- A requester holding req_valid while it is not granted must wait; its command is not sampled.

## Test plan
- Single write then read: requester 0 writes 0xDEADBEEF to 0x8, then reads 0x8.
  - Required: rsp_valid[0] at cycle 3 after each accept, rsp_resp = 0, rsp_rdata = 0xDEADBEEF.
- Contention: both requesters are valid in the same cycle after reset.
  - req0 writes 0x1 to 0x0; req1 writes 0x2 to 0x4.
  - Required: req0 is granted first and req1 at the next IDLE. Reads of 0x0 and 0x4 return 0x1 and 0x2.
- Fairness: both requesters hold req_valid continuously for 8 commands.
  - Required: grants alternate 0,1,0,1,... and no requester is granted twice in a row.
- Backpressure: the slave delays AWREADY 3 cycles and WREADY 1 cycle.
  - Required: WVALID drops after its handshake while AWVALID stays high. BREADY asserts only after both handshakes. Write latency is 6 cycles.
- Error and unaligned address: a read at address 0x6 to a slave returning RRESP = 2'b10.
  - Required: ARADDR = 0x4 and rsp_resp = 2'b10.
- Reset mid-read: ARESET is asserted in RD_DATA before RVALID.
  - Required: no rsp_valid, all outputs 0 the next cycle. After release, a fresh read of 0x0 completes normally with priority on requester 0.
